// File: rtl/normalize_decrementor.sv
// normalize_decrementor: multi-cycle left-normalizer that shifts the mantissa
// until bit 7 is set, decrementing the exponent once per shift.
module normalize_decrementor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] exp_in,
  input  logic [7:0] mant_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] exp_out,
  output logic [7:0] mant_out,
  output logic [2:0] shift_cnt,
  output logic       zero,
  output logic       underflow
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic       fin;
  logic [7:0] exp_n, mant_n;
  logic [2:0] cnt_n;
  logic       zero_n, uf_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    fin = mant_out == 8'h00 || mant_out[7] || exp_out == 8'h00;
    state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
              state == SHIFT ? (fin ? DONE : SHIFT) : IDLE;
  end
  // exp_out/mant_out double as the working registers while shifting
  always_comb begin
    exp_n  = exp_out;
    mant_n = mant_out;
    cnt_n  = shift_cnt;
    zero_n = zero;
    uf_n   = underflow;
    if (state == IDLE && start) begin
      exp_n  = exp_in;
      mant_n = mant_in;
      cnt_n  = 3'd0;
      zero_n = 1'b0;
      uf_n   = 1'b0;
    end else if (state == SHIFT) begin
      if (mant_out == 8'h00) begin
        exp_n  = 8'h00;
        zero_n = 1'b1;
      end else if (!mant_out[7]) begin
        if (exp_out == 8'h00) uf_n = 1'b1;
        else begin
          mant_n = {mant_out[6:0], 1'b0};
          exp_n  = exp_out - 8'd1;
          cnt_n  = shift_cnt + 3'd1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      exp_out   <= 8'h00;
      mant_out  <= 8'h00;
      shift_cnt <= 3'd0;
      zero      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      busy      <= state_n != IDLE;
      done      <= state_n == DONE;
      exp_out   <= exp_n;
      mant_out  <= mant_n;
      shift_cnt <= cnt_n;
      zero      <= zero_n;
      underflow <= uf_n;
    end
endmodule

// File: tb/tb_normalize_decrementor.sv
// tb_normalize_decrementor: directed and randomized checks of the normalizer
// against an arithmetic reference model.
module tb_normalize_decrementor;
  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] exp_in, mant_in;
  logic       busy, done, zero, underflow;
  logic [7:0] exp_out, mant_out;
  logic [2:0] shift_cnt;
  int vectors = 0;
  int miscompares = 0;

  normalize_decrementor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_in(exp_in), .mant_in(mant_in),
    .busy(busy), .done(done), .exp_out(exp_out), .mant_out(mant_out),
    .shift_cnt(shift_cnt), .zero(zero), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Normalization expressed as leading-zero count limited by available exponent
  task automatic model(input logic [7:0] e, input logic [7:0] m, output logic [7:0] eo,
                       output logic [7:0] mo, output int k, output logic z, output logic uf);
    int msb = 0;
    int need;
    z = 1'b0; uf = 1'b0;
    if (m == 8'h00) begin
      z = 1'b1; eo = 8'h00; mo = 8'h00; k = 0;
    end else begin
      for (int i = 0; i < 8; i++) if (m[i]) msb = i;
      need = 7 - msb;
      if (need > int'(e)) begin k = int'(e); uf = 1'b1; end
      else k = need;
      mo = 8'(int'(m) << k);
      eo = 8'(int'(e) - k);
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] e, input logic [7:0] m);
    logic [7:0] eo, mo;
    int k;
    logic z, uf;
    model(e, m, eo, mo, k, z, uf);
    chk({tag, "_exp"}, exp_out, eo);
    chk({tag, "_mant"}, mant_out, mo);
    chk({tag, "_cnt"}, shift_cnt, k);
    chk({tag, "_zero"}, zero, z);
    chk({tag, "_uf"}, underflow, uf);
  endtask

  task automatic run_op(input string tag, input logic [7:0] e, input logic [7:0] m);
    logic [7:0] eo, mo;
    int k, n;
    logic z, uf;
    model(e, m, eo, mo, k, z, uf);
    @(negedge clk);
    start = 1'b1; exp_in = e; mant_in = m;
    @(posedge clk); #1;
    chk({tag, "_busy1"}, busy, 1'b1);
    @(negedge clk);
    start = 1'b0; exp_in = $urandom; mant_in = $urandom;
    n = 1;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    chk({tag, "_lat"}, n, k + 2);
    chk({tag, "_busy"}, busy, 1'b1);
    check_result(tag, e, m);
    @(posedge clk); #1;
    chk({tag, "_donelow"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_hold"}, {exp_out, mant_out}, {eo, mo});
  endtask

  initial begin
    int first_n, second_n, pulses;
    logic [7:0] e, m;
    start = 1'b0; exp_in = 8'h00; mant_in = 8'h00; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outs", {busy, done, exp_out, mant_out, shift_cnt, zero, underflow}, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op("norm0", 8'h10, 8'h80);
    run_op("norm7", 8'h10, 8'h01);
    run_op("zero", 8'h55, 8'h00);
    run_op("uflow", 8'h03, 8'h01);
    run_op("exact", 8'h03, 8'h10);
    run_op("exp0", 8'h00, 8'h40);

    // start held high: second operand only captured once back in IDLE
    @(negedge clk);
    start = 1'b1; exp_in = 8'h10; mant_in = 8'h01;
    @(posedge clk); #1;
    @(negedge clk);
    exp_in = 8'h20; mant_in = 8'h80;
    first_n = 0; second_n = 0; pulses = 0;
    for (int n = 2; n <= 15; n++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (pulses == 1) begin first_n = n; check_result("held1", 8'h10, 8'h01); end
        else begin second_n = n; check_result("held2", 8'h20, 8'h80); end
      end
      if (n == 10) chk("held_gap_busy", busy, 1'b0);
      if (n == 11) start = 1'b0;
    end
    chk("held_first", first_n, 9);
    chk("held_second", second_n, 12);
    chk("held_pulses", pulses, 2);

    // asynchronous reset in the middle of a shift sequence
    @(negedge clk);
    start = 1'b1; exp_in = 8'h20; mant_in = 8'h04;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {busy, done, exp_out, mant_out, shift_cnt, zero, underflow}, 0);
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_nodone", pulses, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", 8'h20, 8'h80);

    for (int i = 0; i < 40; i++) begin
      e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      m = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      run_op("rand", e, m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/normalize_decrementor.md
NORMALIZE_DECREMENTOR -- requirements
Module: normalize_decrementor

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port start  input  1  request to normalize exp_in/mant_in; sampled only in IDLE.
REQ-004 SHALL have port exp_in  input  8  unsigned biased exponent.
REQ-005 SHALL have port mant_in  input  8  unsigned mantissa; bit 7 is the leading-one position.
REQ-006 SHALL have port busy  output  1  high in SHIFT and DONE.
REQ-007 SHALL have port done  output  1  one-cycle result strobe.
REQ-008 SHALL have port exp_out  output  8  decremented exponent.
REQ-009 SHALL have port mant_out  output  8  left-shifted mantissa.
REQ-010 SHALL have port shift_cnt  output  3  number of left shifts applied (0-7).
REQ-011 SHALL have port zero  output  1  mantissa input was zero.
REQ-012 SHALL have port underflow  output  1  exponent reached 0 before mant bit 7 was set.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and DONE; all outputs SHALL be registered.
REQ-014 In IDLE with start=1, SHALL load mant_in and exp_in into working registers, clear shift_cnt, zero and underflow, and go to SHIFT.
REQ-015 In IDLE with start=0, SHALL hold all outputs.
REQ-016 In SHIFT, each cycle SHALL evaluate in priority order: (a) mant==0 -> exp=0, zero=1, go DONE; (b) mant[7]==1 -> go DONE; (c) exp==0 -> underflow=1, go DONE; (d) otherwise mant<<=1 with a 0 fill, exp-=1, shift_cnt+=1, stay in SHIFT.
REQ-017 Exponent decrement SHALL never go below 0 (guaranteed by rule c); it SHALL never wrap to 0xFF.
REQ-018 shift_cnt SHALL never exceed 7; a nonzero 8-bit mantissa normalizes in at most 7 shifts.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 exp_out, mant_out, shift_cnt, zero and underflow SHALL hold their values from DONE until the next accepted start.
REQ-021 For k shifts, done SHALL be high in the cycle after the (k+2)th rising edge, counting the edge that samples start as edge 1.
REQ-022 start asserted in SHIFT or DONE SHALL be ignored; it SHALL not be queued.
REQ-023 busy SHALL be 0 in IDLE and 1 in SHIFT and DONE; done and busy SHALL never rise in IDLE.
REQ-024 zero and underflow SHALL never both be 1; when zero=1, mant_out=0x00, exp_out=0x00 and shift_cnt=0.
REQ-025 When underflow=1, mant_out and exp_out SHALL hold the partially shifted mantissa and exp=0.

Reset
REQ-026 rst_n=0 SHALL immediately force the FSM to IDLE and set busy, done, zero, underflow, shift_cnt, exp_out and mant_out to 0, independent of clk.
REQ-027 Reset asserted during SHIFT or DONE SHALL abort the operation without producing a done pulse.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-029 exp_in=0x10, mant_in=0x80, start pulse -> done after edge 2; mant_out=0x80, exp_out=0x10, shift_cnt=0, zero=0, underflow=0.
REQ-030 exp_in=0x10, mant_in=0x01 -> done after edge 9; mant_out=0x80, exp_out=0x09, shift_cnt=7.
REQ-031 exp_in=0x55, mant_in=0x00 -> done after edge 2; zero=1, mant_out=0x00, exp_out=0x00, shift_cnt=0.
REQ-032 exp_in=0x03, mant_in=0x01 -> done after edge 5; underflow=1, mant_out=0x08, exp_out=0x00, shift_cnt=3.
REQ-033 start held high through an operation with new inputs -> second operand not captured until start is sampled in IDLE; done pulses once per accepted start.
REQ-034 rst_n pulsed low mid-SHIFT (exp_in=0x20, mant_in=0x04) -> all outputs 0 immediately, no done; a following start with 0x20/0x80 completes normally.
